sram_ctrl: RTL

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready front end for a single-port SRAM.
// Registered strobes, pipelined reads, in-order response FIFO.
module sram_ctrl #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 256,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                sram_en,
    output logic                sram_we,
    output logic [DATA_W/8-1:0] sram_be,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_din,
    input  logic [DATA_W-1:0]   sram_dout
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic              rdy_en;
    logic [CW-1:0]     outst;
    logic [RD_LAT-1:0] rd_pipe;
    logic [PW:0]       wr_ptr;
    logic [PW:0]       rd_ptr;
    logic [DATA_W-1:0] fifo [RSP_DEPTH];
    logic              accept;
    logic              rd_acc;
    logic              wr_acc;
    logic              strobe_rd;
    logic              push;
    logic              pop;

    // Writes never need a response slot, so only reads are throttled.
    assign req_ready = rdy_en & (req_we | (outst < CW'(RSP_DEPTH)));
    assign accept    = req_valid & req_ready;
    assign rd_acc    = accept & ~req_we;
    assign wr_acc    = accept & req_we & (|req_be);
    assign strobe_rd = sram_en & ~sram_we;
    assign push      = rd_pipe[RD_LAT-1];
    assign rsp_valid = (wr_ptr != rd_ptr);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_rdata = rsp_valid ? fifo[rd_ptr[PW-1:0]] : '0;

    // Request register stage: one SRAM strobe per accepted access.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_en    <= 1'b0;
            sram_en   <= 1'b0;
            sram_we   <= 1'b0;
            sram_be   <= '0;
            sram_addr <= '0;
            sram_din  <= '0;
        end else begin
            rdy_en  <= 1'b1;
            sram_en <= rd_acc | wr_acc;
            sram_we <= wr_acc;
            sram_be <= wr_acc ? req_be : '0;
            if (rd_acc | wr_acc) begin
                sram_addr <= req_addr;
            end
            if (wr_acc) begin
                sram_din <= req_wdata;
            end
        end
    end

    // Read-latency valid pipeline; last stage marks sram_dout as valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= strobe_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    // FIFO pointers and outstanding reads (in flight plus queued).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            outst  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
            outst <= outst + CW'(rd_acc) - CW'(pop);
        end
    end

    // FIFO storage; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr[PW-1:0]] <= sram_dout;
        end
    end
endmodule
